// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared FSM states, ALU opcodes and flag bit positions for alu_arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_LSA  = 4'b0110;
  localparam logic [3:0] OP_RSA  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_RSL  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_LAST = 4'b1010;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// rtl/alu_arb_rr.sv - two-way round-robin pick: prio wins if valid, else the other requester
module alu_arb_rr (
  input  logic       prio,
  input  logic [1:0] valid,
  output logic [1:0] grant_oh,
  output logic       grant_idx
);

  always_comb begin
    grant_oh  = 2'b00;
    grant_idx = prio;
    if (valid[prio]) begin
      grant_idx      = prio;
      grant_oh[prio] = 1'b1;
    end else if (valid[~prio]) begin
      grant_idx       = ~prio;
      grant_oh[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_n_bits.sv
// rtl/alu_n_bits.sv - combinational N-bit ALU; shifts move A by the amount in B, MOV passes B
module ALU_N_bits
  import alu_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alu_control,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic         carry;
  logic         ovf;

  always_comb begin
    is_sub = (alu_control == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    carry  = 1'b0;
    ovf    = 1'b0;
    result = '0;
    case (alu_control)
      // SUB carry is the inverted borrow (A >= B unsigned)
      OP_ADD, OP_SUB: begin
        result = sum[N-1:0];
        carry  = sum[N];
        ovf    = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_LSA:  result = a <<< b;
      OP_RSA:  result = N'($signed(a) >>> b);
      OP_LSL:  result = a << b;
      OP_RSL:  result = a >> b;
      OP_MOV:  result = b;
      default: result = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[N-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two requesters share one ALU_N_bits via round-robin IDLE/EXEC/RESP FSM
// Optional owner lock enabled by defining ALU_ARB_LOCK_EN (adds req_lock port).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][3:0]      req_op,
  input  logic [NREQ-1:0][N-1:0]    req_a,
  input  logic [NREQ-1:0][N-1:0]    req_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [N-1:0]              rsp_result,
  output logic [3:0]                rsp_flags,
  output logic                      rsp_err
);

  state_t       state;
  logic         prio;
  logic         owner;
  logic [3:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [1:0]   rr_valid;
  logic         rr_prio;
  logic [1:0]   grant_oh;
  logic         grant_idx;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

`ifdef ALU_ARB_LOCK_EN
  logic lock_active;
  logic lock_idx;

  // While locked, only the lock holder is visible to the picker.
  always_comb begin
    rr_valid = req_valid;
    rr_prio  = prio;
    if (lock_active) begin
      rr_valid = req_valid & (lock_idx ? 2'b10 : 2'b01);
      rr_prio  = lock_idx;
    end
  end
`else
  always_comb begin
    rr_valid = req_valid;
    rr_prio  = prio;
  end
`endif

  alu_arb_rr u_rr (
    .prio      (rr_prio),
    .valid     (rr_valid),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst) req_ready = grant_oh;
  end

  ALU_N_bits #(.N(N)) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_result),
    .flags       (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_idx    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant_oh) begin
            owner <= grant_idx;
            op_q  <= req_op[grant_idx];
            a_q   <= req_a[grant_idx];
            b_q   <= req_b[grant_idx];
            state <= EXEC;
`ifdef ALU_ARB_LOCK_EN
            if (!lock_active) prio <= ~grant_idx;
            lock_active <= req_lock[grant_idx];
            lock_idx    <= grant_idx;
`else
            prio <= ~grant_idx;
`endif
          end
        end
        EXEC: begin
          // Illegal opcodes never take the ALU's output.
          if (op_is_legal(op_q)) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end
          rsp_valid[owner] <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (lock steps when ALU_ARB_LOCK_EN)
module tb_alu_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][3:0] req_op;
  logic [1:0][3:0] req_a;
  logic [1:0][3:0] req_b;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]      req_lock;
`endif
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [3:0]      rsp_result;
  logic [3:0]      rsp_flags;
  logic            rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(4), .NREQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge with the DUT in IDLE; only requester idx is valid.
  task automatic do_op(input int idx, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] er, input logic [3:0] ef,
                       input logic ee);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    req_valid   = oh;
    req_op[idx] = op;
    req_a[idx]  = a;
    req_b[idx]  = b;
    #1 chk("op_ready", {6'd0, req_ready}, {6'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("op_exec_no_rsp", {6'd0, rsp_valid}, 8'h00);
    @(negedge clk);
    chk("op_rsp_valid", {6'd0, rsp_valid}, {6'd0, oh});
    chk("op_result", {4'd0, rsp_result}, {4'd0, er});
    chk("op_flags", {4'd0, rsp_flags}, {4'd0, ef});
    chk("op_err", {7'd0, rsp_err}, {7'd0, ee});
    @(negedge clk);
    chk("op_rsp_done", {6'd0, rsp_valid}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b11;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {6'd0, req_ready}, 8'h00);
    chk("rst_rsp_valid", {6'd0, rsp_valid}, 8'h00);
    chk("rst_result", {4'd0, rsp_result}, 8'h00);
    chk("rst_flags", {4'd0, rsp_flags}, 8'h00);
    chk("rst_err", {7'd0, rsp_err}, 8'h00);
    rst = 1'b0;

    // Single request: 0011 + 1010 = 1101, N set
    do_op(0, 4'b0000, 4'b0011, 4'b1010, 4'b1101, 4'b1000, 1'b0);

    // Contention from reset: alternating grants over six back-to-back ops
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    req_op[0] = 4'b0001; req_a[0] = 4'b1010; req_b[0] = 4'b0011;
    req_op[1] = 4'b0010; req_a[1] = 4'b0011; req_b[1] = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1 chk("cont_ready", {6'd0, req_ready}, (k % 2 == 0) ? 8'h01 : 8'h02);
      @(negedge clk);
      @(negedge clk);
      chk("cont_rsp_valid", {6'd0, rsp_valid}, (k % 2 == 0) ? 8'h01 : 8'h02);
      chk("cont_result", {4'd0, rsp_result}, (k % 2 == 0) ? 8'h07 : 8'h02);
      chk("cont_flags", {4'd0, rsp_flags}, (k % 2 == 0) ? 8'h03 : 8'h00);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Backpressure on requester 1; non-owner rsp_ready is high and must be ignored
    req_valid = 2'b10;
    req_op[1] = 4'b0011; req_a[1] = 4'b0101; req_b[1] = 4'b1000;
    rsp_ready = 2'b01;
    #1 chk("bp_ready", {6'd0, req_ready}, 8'h02);
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_rsp_valid", {6'd0, rsp_valid}, 8'h02);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {6'd0, rsp_valid}, 8'h02);
      chk("bp_hold_result", {4'd0, rsp_result}, 8'h0d);
      chk("bp_hold_flags", {4'd0, rsp_flags}, 8'h08);
      chk("bp_ready_low", {6'd0, req_ready}, 8'h00);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_done", {6'd0, rsp_valid}, 8'h00);

    // Illegal opcodes and the OP_LAST boundary
    do_op(0, 4'b1100, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    do_op(0, 4'b0100, 4'b0110, 4'b0101, 4'b0011, 4'b0000, 1'b0);
    do_op(1, 4'b0111, 4'b1000, 4'b0001, 4'b1100, 4'b1000, 1'b0);
    do_op(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    do_op(1, 4'b1010, 4'b0000, 4'b1001, 4'b1001, 4'b1000, 1'b0);
    do_op(1, 4'b1011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);

    // Reset while in EXEC: the op is dropped, then requester 0 wins a tie
    req_valid = 2'b10;
    req_op[1] = 4'b0001; req_a[1] = 4'b0000; req_b[1] = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    req_op[0] = 4'b0000; req_a[0] = 4'b0001; req_b[0] = 4'b0001;
    @(negedge clk);
    chk("rst_mid_ready", {6'd0, req_ready}, 8'h00);
    chk("rst_mid_rsp", {6'd0, rsp_valid}, 8'h00);
    @(negedge clk);
    chk("rst_mid_ready2", {6'd0, req_ready}, 8'h00);
    chk("rst_mid_rsp2", {6'd0, rsp_valid}, 8'h00);
    rst = 1'b0;
    #1 chk("rst_tie_ready", {6'd0, req_ready}, 8'h01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rst_post_exec", {6'd0, rsp_valid}, 8'h00);
    @(negedge clk);
    chk("rst_post_rsp", {6'd0, rsp_valid}, 8'h01);
    chk("rst_post_result", {4'd0, rsp_result}, 8'h02);
    @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 holds the lock for three ops, releasing it on the third
    req_lock  = 2'b10;
    req_valid = 2'b11;
    req_op[1] = 4'b0011; req_a[1] = 4'b0001; req_b[1] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_lock = 2'b00;
      #1 chk("lock_ready", {6'd0, req_ready}, 8'h02);
      @(negedge clk);
      @(negedge clk);
      chk("lock_rsp_valid", {6'd0, rsp_valid}, 8'h02);
      chk("lock_result", {4'd0, rsp_result}, 8'h03);
      @(negedge clk);
    end
    #1 chk("unlock_ready", {6'd0, req_ready}, 8'h01);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU_N_bits instance between two requesters (e.g. execute-stage issue and address-generation unit).
- Round-robin arbitration.
- Registered operands and results.
- valid/ready handshakes on both the request and response sides.
- Illegal opcodes are rejected with an error response; the ALU is not used for them.

Parameters:
N, 4, datapath width of operands and result (passed to ALU_N_bits)
NREQ, 2, number of requesters (fixed at 2; other values unsupported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept; one-hot or zero
req_op  input  2x4  per-requester ALUControl opcode
req_a  input  2xN  per-requester operand A
req_b  input  2xN  per-requester operand B
rsp_valid  output  2  per-requester response valid; one-hot or zero
rsp_ready  input  2  per-requester response accept
rsp_result  output  N  shared result bus
rsp_flags  output  4  shared flags bus, {N,Z,C,V} as produced by ALU_N_bits
rsp_err  output  1  response is for an illegal opcode

Behaviour:
- Reset: state=IDLE, prio=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0. A reset during EXEC or RESP discards the operation; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = prio if req_valid[prio], else the other requester if it is valid, else none.
  - req_ready[grant]=1, combinational, in IDLE only.
  - On valid&ready: latch op/a/b/owner, set prio = ~owner, go to EXEC.
  - No request: stay in IDLE.
- EXEC (1 cycle):
  - Legal opcode (0000..1010: ADD,SUB,AND,OR,XOR,NOT,LSA,RSA,LSL,RSL,MOV): the ALU sees the registered operands; RESULT and flags are registered into rsp_result/rsp_flags, rsp_err=0.
  - Illegal opcode (1011..1111): rsp_result=0, rsp_flags=0, rsp_err=1.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; data is held stable until rsp_ready[owner]=1.
  - On handshake: rsp_valid=0 on the next cycle, go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: accept at cycle t gives rsp_valid at t+2. Minimum issue interval is 3 cycles (accept, EXEC, RESP handshake).
- Requester rules:
  - Request fields are sampled only at the accept edge.
  - A requester may drop valid before it is accepted; no state is affected.
  - Both requesters continuously valid get strictly alternating grants.
- Datapath: result width N. No sign/zero extension. Carry/overflow come from the ALU only.

Optional Feature:
Macro ALU_ARB_LOCK_EN.
- Defined:
  - Adds port req_lock (input, 2).
  - If req_lock[owner]=1 at accept, the arbiter records lock=owner.
  - In the following IDLE phases, only the locked owner may be granted; the other requester's ready stays 0.
  - The lock clears when the owner has an accepted request with req_lock=0, or on reset.
  - While locked, prio is not updated.
- Undefined: port absent, pure round-robin as above.

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE,EXEC,RESP}.
  - Opcode localparams OP_ADD..OP_MOV with OP_LAST=4'b1010.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_arb_rr: combinational 2-way round-robin pick. Inputs prio and valid[1:0]; outputs grant_oh[1:0] and grant_idx.
- The ALU_N_bits instance lives in alu_arbiter.

Test Plan:
- Single request: after reset, req0 ADD a=0011 b=1010, rsp_ready=1 -> req_ready[0] in the same cycle; rsp_valid[0] at t+2 with result 1101, flags N=1 Z=0, rsp_err=0.
- Contention: both valid from reset, req0 SUB 1010-0011, req1 AND 0011&1010 -> req0 served first (result 0111), then req1 (result 0010); grants alternate over 4 further back-to-back requests.
- Backpressure: rsp_ready[1]=0 for 5 cycles during RESP -> rsp_valid[1] and data held stable; req_ready stays 0 throughout; completes one cycle after rsp_ready rises.
- Illegal op: req0 op=1100 -> rsp_err=1, result 0000, flags 0000, latency 2; the next legal request works normally.
- Reset mid-op: assert rst in EXEC -> no rsp_valid at any time; req_ready=0 while rst is asserted, then IDLE with prio=0 (req0 wins the tie).
- ALU_ARB_LOCK_EN: req1 locks, both requesters valid for 3 ops -> req1 granted 3 times; unlocking grants req0 next.
